ha_result_checker: RTL and testbench

Self-checking receiver for the half-adder stimulus sequence. It samples each applied (a, b) vector together with the DUT's carry/sum response, compares the response against the golden half-adder function, and counts vectors and mismatches. It also tracks which input combinations have been exercised and raises a verdict when the run completes. It sits at the observing end of a half-adder bench, opposite the stimulus driver.

---
 rtl/ha_result_checker.sv | 93 +++++++++
 tb/tb_ha_result_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ha_result_checker.sv
// ha_result_checker: scores half-adder responses against a&b / a^b, counts vectors,
// errors and input coverage, and reports a pass/timeout verdict at end of run.
module ha_result_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_c,
    input  logic             in_s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       coverage,
    output logic [CNT_W-1:0] first_err_idx
);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    logic [1:0] state;
    logic [IW-1:0] idle_cnt;
    logic bad, last, idle_hit;
    logic [CNT_W-1:0] err_next;
    logic [3:0] cov_next;
    always_comb begin
        bad = (in_c != (in_a & in_b)) || (in_s != (in_a ^ in_b));
        err_next = (bad && err_count != ALL_ONES) ? err_count + 1'b1 : err_count;
        cov_next = coverage | (4'b0001 << {in_a, in_b});
        last = vec_count == CNT_W'(NUM_VECTORS - 1);
        idle_hit = idle_cnt == IW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            timeout <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            coverage <= '0;
            first_err_idx <= ALL_ONES;
            idle_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= RUN;
                    busy <= 1'b1;
                    done <= 1'b0;
                    pass <= 1'b0;
                    timeout <= 1'b0;
                    vec_count <= '0;
                    err_count <= '0;
                    coverage <= '0;
                    first_err_idx <= ALL_ONES;
                    idle_cnt <= '0;
                end
                RUN: if (in_valid) begin
                    vec_count <= vec_count + 1'b1;
                    err_count <= err_next;
                    coverage <= cov_next;
                    idle_cnt <= '0;
                    if (bad && err_count == '0) first_err_idx <= vec_count;
                    // A sample on the timeout boundary still completes the run normally
                    if (last) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= err_next == '0 && cov_next == 4'hF;
                    end
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                    if (idle_hit) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        timeout <= 1'b1;
                        pass <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ha_result_checker.sv
// tb_ha_result_checker: directed test plan plus randomized runs, checked every cycle
// against a sample-log reference model; a second instance covers the 255-vector case.
module tb_ha_result_checker;
    localparam int NV = 4;
    localparam int TO = 16;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst, start, in_valid, in_a, in_b, in_c, in_s;
    logic busy, done, pass, timeout;
    logic [W-1:0] vec_count, err_count, first_err_idx;
    logic [3:0] coverage;
    logic busy2, done2, pass2, timeout2;
    logic [W-1:0] vec_count2, err_count2, first_err_idx2;
    logic [3:0] coverage2;
    int n_checks = 0;
    int n_fail = 0;
    bit m_busy, m_done, m_to;
    int m_idle;
    bit [2:0] run_log[$];

    always #5 clk = ~clk;

    ha_result_checker #(.NUM_VECTORS(NV), .CNT_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_s(in_s),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .vec_count(vec_count), .err_count(err_count), .coverage(coverage),
        .first_err_idx(first_err_idx)
    );

    ha_result_checker #(.NUM_VECTORS(255), .CNT_W(W), .TIMEOUT(TO)) dut_long (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_s(in_s),
        .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2),
        .vec_count(vec_count2), .err_count(err_count2), .coverage(coverage2),
        .first_err_idx(first_err_idx2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a run is just the log of accepted samples; all counters derive from it
    task automatic model(input bit r, input bit st, input bit v, input bit a, input bit b,
                         input bit c, input bit s);
        bit bad;
        bad = (c != (a & b)) || (s != (a ^ b));
        if (r) begin
            m_busy = 0; m_done = 0; m_to = 0; m_idle = 0; run_log.delete();
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_done = 0; m_to = 0; m_idle = 0; run_log.delete();
            end
        end else if (v) begin
            run_log.push_back({bad, a, b});
            m_idle = 0;
            if (run_log.size() == NV) begin m_busy = 0; m_done = 1; end
        end else begin
            m_idle++;
            if (m_idle == TO) begin m_busy = 0; m_done = 1; m_to = 1; end
        end
    endtask

    task automatic compare();
        int nbad, first;
        bit [3:0] cov;
        nbad = 0; first = 255; cov = 0;
        foreach (run_log[i]) begin
            if (run_log[i][2]) begin
                if (nbad == 0) first = i;
                nbad++;
            end
            cov[run_log[i][1:0]] = 1'b1;
        end
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("timeout", timeout, m_to);
        check("pass", pass, m_done && !m_to && nbad == 0 && cov == 4'hF);
        check("vec_count", vec_count, run_log.size());
        check("err_count", err_count, nbad > 255 ? 255 : nbad);
        check("coverage", coverage, cov);
        check("first_err_idx", first_err_idx, first);
    endtask

    task automatic cycle(input bit r, input bit st, input bit v, input bit a, input bit b,
                         input bit c, input bit s);
        rst = r; start = st; in_valid = v; in_a = a; in_b = b; in_c = c; in_s = s;
        @(posedge clk);
        model(r, st, v, a, b, c, s);
        #1;
        compare();
    endtask

    task automatic go();
        cycle(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample(input bit a, input bit b, input bit c, input bit s);
        cycle(0, 0, 1, a, b, c, s);
    endtask

    task automatic good4();
        sample(0, 0, 0, 0); sample(1, 0, 0, 1); sample(0, 1, 0, 1); sample(1, 1, 1, 0);
    endtask

    task automatic rand_sample();
        bit a, b, c, s;
        a = 1'($urandom); b = 1'($urandom);
        c = a & b; s = a ^ b;
        if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) c = ~c; else s = ~s;
        end
        sample(a, b, c, s);
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("reset first_err_idx", first_err_idx, 8'hFF);
        // Plan 1: all four combinations, correct responses
        go(); good4();
        check("t1 pass", pass, 1); check("t1 done", done, 1); check("t1 cov", coverage, 4'hF);
        // Plan 2: third sample has wrong sum
        go(); sample(0, 0, 0, 0); sample(1, 0, 0, 1); sample(0, 1, 0, 0); sample(1, 1, 1, 0);
        check("t2 pass", pass, 0); check("t2 err", err_count, 1); check("t2 first", first_err_idx, 2);
        // Plan 3: stall after two samples
        go(); sample(0, 0, 0, 0); sample(1, 0, 0, 1);
        repeat (TO - 1) idle();
        check("t3 not yet done", done, 0);
        idle();
        check("t3 timeout", timeout, 1); check("t3 vec", vec_count, 2);
        sample(1, 1, 1, 0);
        check("t3 holds vec", vec_count, 2);
        // Plan 4: correct but incomplete coverage
        go(); repeat (4) sample(1, 1, 1, 0);
        check("t4 cov", coverage, 4'b1000); check("t4 pass", pass, 0);
        // Plan 5: reset mid-run, then clean run
        go(); sample(0, 0, 0, 0); sample(1, 0, 0, 1);
        start = 1; in_valid = 0;
        @(posedge clk); #1;
        check("t5 restart ignored", vec_count, 2);
        model(0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("t5 reset vec", vec_count, 0); check("t5 reset busy", busy, 0);
        go(); good4();
        check("t5 pass", pass, 1);
        // Boundary: final sample on the would-be timeout cycle
        go(); sample(0, 0, 0, 0); sample(1, 0, 0, 1); sample(0, 1, 0, 1);
        repeat (TO - 1) idle();
        sample(1, 1, 1, 0);
        check("boundary pass", pass, 1); check("boundary timeout", timeout, 0);
        // Randomized runs
        for (int r = 0; r < 60; r++) begin
            go();
            repeat ($urandom_range(1, 8)) begin
                int k;
                k = $urandom_range(0, 9);
                if (k < 6) rand_sample();
                else if (k < 8) idle();
                else if (k == 8) repeat ($urandom_range(10, 18)) idle();
                else cycle(0, 1, 1, 1, 1, 1, 0);
            end
            if ($urandom_range(0, 9) == 0) cycle(1, 0, 0, 0, 0, 0, 0);
        end
        // Plan 6: 255 mismatching samples on the long instance
        cycle(1, 0, 0, 0, 0, 0, 0);
        go();
        repeat (255) sample(0, 0, 1, 0);
        check("t6 err", err_count2, 255); check("t6 vec", vec_count2, 255);
        check("t6 first", first_err_idx2, 0); check("t6 done", done2, 1);
        check("t6 pass", pass2, 0); check("t6 timeout", timeout2, 0);
        repeat (3) sample(0, 0, 1, 0);
        check("t6 err hold", err_count2, 255); check("t6 vec hold", vec_count2, 255);
        go();
        check("t6 restart vec", vec_count2, 0); check("t6 restart err", err_count2, 0);
        check("t6 restart busy", busy2, 1); check("t6 restart done", done2, 0);
        check("t6 restart first", first_err_idx2, 8'hFF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
